// File: rtl/idct4_transpose_buf.sv
// Ping-pong 4x4 transpose buffer: rows in, columns out, two banks so one block
// fills while the other drains at one beat per cycle.
module idct4_transpose_buf #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             ap_clk,
    input  logic             ap_rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_d0,
    input  logic [WIDTH-1:0] in_d1,
    input  logic [WIDTH-1:0] in_d2,
    input  logic [WIDTH-1:0] in_d3,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_d0,
    output logic [WIDTH-1:0] out_d1,
    output logic [WIDTH-1:0] out_d2,
    output logic [WIDTH-1:0] out_d3,
    output logic             out_last
);

    // Sample storage, indexed [bank][row][col]; never reset.
    logic [WIDTH-1:0] r_mem [2][4][4];

    logic [1:0] r_full;
    logic       r_wr_bank;
    logic [1:0] r_wr_row;
    logic       r_rd_bank;
    logic [1:0] r_rd_col;

    logic [1:0] w_full_d;
    logic       w_wr_fire;
    logic       w_rd_fire;
    logic       w_wr_done;
    logic       w_rd_done;

    // Ready/valid come only from registered flags, never from the other side's handshake.
    assign in_ready  = ~r_full[r_wr_bank];
    assign out_valid = r_full[r_rd_bank];
    assign out_last  = out_valid & (r_rd_col == 2'd3);

    assign w_wr_fire = in_valid & in_ready;
    assign w_rd_fire = out_valid & out_ready;
    assign w_wr_done = w_wr_fire & (r_wr_row == 2'd3);
    assign w_rd_done = w_rd_fire & (r_rd_col == 2'd3);

    // Store the accepted row into the current write bank.
    always_ff @(posedge ap_clk) begin
        if (w_wr_fire) begin
            r_mem[r_wr_bank][r_wr_row][0] <= in_d0;
            r_mem[r_wr_bank][r_wr_row][1] <= in_d1;
            r_mem[r_wr_bank][r_wr_row][2] <= in_d2;
            r_mem[r_wr_bank][r_wr_row][3] <= in_d3;
        end
    end

    // Bank flags: completing write and completing read always target different banks,
    // so both updates apply together.
    always_comb begin
        w_full_d = r_full;
        if (w_wr_done) begin
            w_full_d[r_wr_bank] = 1'b1;
        end
        if (w_rd_done) begin
            w_full_d[r_rd_bank] = 1'b0;
        end
    end

    // Pointer and flag state; reset discards any partial or buffered block.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_full    <= 2'b00;
            r_wr_bank <= 1'b0;
            r_wr_row  <= 2'd0;
            r_rd_bank <= 1'b0;
            r_rd_col  <= 2'd0;
        end else begin
            r_full <= w_full_d;
            if (w_wr_fire) begin
                r_wr_row <= r_wr_row + 2'd1;
            end
            if (w_wr_done) begin
                r_wr_bank <= ~r_wr_bank;
            end
            if (w_rd_fire) begin
                r_rd_col <= r_rd_col + 2'd1;
            end
            if (w_rd_done) begin
                r_rd_bank <= ~r_rd_bank;
            end
        end
    end

    // Column read mux; outputs forced to zero while no column is valid.
    always_comb begin
        out_d0 = '0;
        out_d1 = '0;
        out_d2 = '0;
        out_d3 = '0;
        if (out_valid) begin
            out_d0 = r_mem[r_rd_bank][0][r_rd_col];
            out_d1 = r_mem[r_rd_bank][1][r_rd_col];
            out_d2 = r_mem[r_rd_bank][2][r_rd_col];
            out_d3 = r_mem[r_rd_bank][3][r_rd_col];
        end
    end

endmodule

// File: tb/tb_idct4_transpose_buf.sv
// Self-checking bench for idct4_transpose_buf: directed scenarios plus a random
// stall run, checked against a block-level transpose scoreboard.
module tb_idct4_transpose_buf;

    localparam int unsigned WIDTH = 8;

    logic             ap_clk;
    logic             ap_rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_d0, in_d1, in_d2, in_d3;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_d0, out_d1, out_d2, out_d3;
    logic             out_last;

    idct4_transpose_buf #(.WIDTH(WIDTH)) u_dut (
        .ap_clk    (ap_clk),
        .ap_rst_n  (ap_rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_d0     (in_d0),
        .in_d1     (in_d1),
        .in_d2     (in_d2),
        .in_d3     (in_d3),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_d0    (out_d0),
        .out_d1    (out_d1),
        .out_d2    (out_d2),
        .out_d3    (out_d3),
        .out_last  (out_last)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Scoreboard: rows of the block being filled, queue of expected columns,
    // and counts of completed / fully drained blocks (capacity is two blocks).
    logic [WIDTH-1:0]   m_blk [4][4];
    logic [4*WIDTH-1:0] m_q [$];
    int                 m_rows;
    int                 m_done;
    int                 m_drained;
    int                 m_cols;
    logic               mdl_in_fire;
    logic               dut_in_fire;
    logic               dut_out_fire;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_q.delete();
        m_rows    = 0;
        m_done    = 0;
        m_drained = 0;
        m_cols    = 0;
    endtask

    task automatic drive_row(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                             input logic [WIDTH-1:0] c, input logic [WIDTH-1:0] d);
        in_d0 = a;
        in_d1 = b;
        in_d2 = c;
        in_d3 = d;
    endtask

    task automatic drive_random_row();
        drive_row(WIDTH'($urandom), WIDTH'($urandom), WIDTH'($urandom), WIDTH'($urandom));
    endtask

    // One clock cycle: compare at the falling edge, advance the model, return 1ns
    // after the next rising edge so the caller can drive the following cycle.
    task automatic tick();
        int undrained;
        undrained = m_done - m_drained;
        @(negedge ap_clk);
        check("in_ready", {31'b0, in_ready}, {31'b0, (undrained < 2)});
        check("out_valid", {31'b0, out_valid}, {31'b0, (undrained > 0)});
        if (undrained > 0) begin
            check("out_col", {out_d3, out_d2, out_d1, out_d0}, m_q[0]);
            check("out_last", {31'b0, out_last}, {31'b0, ((m_cols % 4) == 3)});
        end else begin
            check("out_idle_zero", {out_d3, out_d2, out_d1, out_d0}, 32'h0);
        end
        dut_in_fire  = in_valid & in_ready;
        dut_out_fire = out_valid & out_ready;
        mdl_in_fire  = in_valid && (undrained < 2);
        if (undrained > 0 && out_ready) begin
            void'(m_q.pop_front());
            m_cols++;
            if (m_cols % 4 == 0) m_drained++;
        end
        if (mdl_in_fire) begin
            m_blk[m_rows][0] = in_d0;
            m_blk[m_rows][1] = in_d1;
            m_blk[m_rows][2] = in_d2;
            m_blk[m_rows][3] = in_d3;
            m_rows++;
            if (m_rows == 4) begin
                for (int c = 0; c < 4; c++) begin
                    m_q.push_back({m_blk[3][c], m_blk[2][c], m_blk[1][c], m_blk[0][c]});
                end
                m_done++;
                m_rows = 0;
            end
        end
        @(posedge ap_clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        ap_rst_n  = 1'b0;
        #1;
        model_reset();
        @(posedge ap_clk);
        #1;
        ap_rst_n = 1'b1;
    endtask

    initial begin
        int vals [4];
        int cnt;
        int cyc;
        int k;
        int first_in;
        logic [WIDTH-1:0] od [4];

        vals = '{-128, 127, -1, 0};
        in_valid  = 1'b0;
        out_ready = 1'b0;
        drive_row('0, '0, '0, '0);
        model_reset();
        ap_rst_n = 1'b0;
        #1;
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_out_last", {31'b0, out_last}, 32'd0);
        check("rst_out_d", {out_d3, out_d2, out_d1, out_d0}, 32'h0);
        @(posedge ap_clk);
        #1;
        ap_rst_n = 1'b1;

        // Single block, values 0..15: column c on cycle 4+c holds {4i+c}.
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int r = 0; r < 4; r++) begin
            drive_row(WIDTH'(4*r), WIDTH'(4*r+1), WIDTH'(4*r+2), WIDTH'(4*r+3));
            tick();
            if (r == 3) in_valid = 1'b0;
        end
        for (int c = 0; c < 4; c++) begin
            od = '{out_d0, out_d1, out_d2, out_d3};
            check("t1_valid", {31'b0, out_valid}, 32'd1);
            for (int i = 0; i < 4; i++) begin
                check("t1_elem", {24'b0, od[i]}, 32'(4*i + c));
            end
            check("t1_last", {31'b0, out_last}, {31'b0, (c == 3)});
            tick();
        end
        check("t1_drained", {31'b0, out_valid}, 32'd0);

        // Throughput: 8 blocks back-to-back, 32 columns in the 32-cycle window.
        do_reset();
        out_ready = 1'b1;
        cnt = 0;
        for (int cy = 0; cy < 36; cy++) begin
            in_valid = (cy < 32);
            if (cy < 32) begin
                drive_random_row();
                check("t2_in_ready", {31'b0, in_ready}, 32'd1);
            end
            tick();
            if (dut_out_fire) cnt++;
        end
        check("t2_col_count", 32'(cnt), 32'd32);

        // Backpressure: 3 blocks offered with out_ready low; only 8 rows fit.
        do_reset();
        k   = 0;
        cnt = 0;
        in_valid = 1'b1;
        for (int cy = 0; cy < 14; cy++) begin
            drive_row(WIDTH'(4*k), WIDTH'(4*k+1), WIDTH'(4*k+2), WIDTH'(4*k+3));
            tick();
            if (dut_in_fire) cnt++;
            if (mdl_in_fire) k++;
        end
        check("t3_rows_taken", 32'(cnt), 32'd8);
        check("t3_in_ready_low", {31'b0, in_ready}, 32'd0);
        check("t3_hold_col0", {out_d3, out_d2, out_d1, out_d0}, {8'd12, 8'd8, 8'd4, 8'd0});
        out_ready = 1'b1;
        first_in  = -1;
        cyc = 0;
        while ((k < 12 || m_q.size() > 0) && cyc < 60) begin
            in_valid = (k < 12);
            drive_row(WIDTH'(4*k), WIDTH'(4*k+1), WIDTH'(4*k+2), WIDTH'(4*k+3));
            tick();
            if (dut_in_fire && first_in < 0) first_in = cyc;
            if (mdl_in_fire) k++;
            cyc++;
        end
        in_valid = 1'b0;
        check("t3_first_refill_cycle", 32'(first_in), 32'd4);
        check("t3_all_drained", 32'(m_drained), 32'd3);

        // Signed extremes pass bit-exact.
        do_reset();
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int r = 0; r < 4; r++) begin
            drive_row(WIDTH'(vals[r % 4]), WIDTH'(vals[(r+1) % 4]),
                      WIDTH'(vals[(r+2) % 4]), WIDTH'(vals[(r+3) % 4]));
            tick();
            if (r == 3) in_valid = 1'b0;
        end
        for (int c = 0; c < 4; c++) begin
            od = '{out_d0, out_d1, out_d2, out_d3};
            for (int i = 0; i < 4; i++) begin
                check("t4_signed", 32'($signed(od[i])), 32'(vals[(i+c) % 4]));
            end
            tick();
        end

        // Reset mid-block with the other bank full.
        do_reset();
        in_valid = 1'b1;
        cnt = 0;
        cyc = 0;
        while (cnt < 6 && cyc < 20) begin
            drive_random_row();
            tick();
            if (mdl_in_fire) cnt++;
            cyc++;
        end
        in_valid = 1'b0;
        check("t5_pre_valid", {31'b0, out_valid}, 32'd1);
        #2;
        ap_rst_n = 1'b0;
        #1;
        check("t5_rst_valid", {31'b0, out_valid}, 32'd0);
        check("t5_rst_ready", {31'b0, in_ready}, 32'd1);
        check("t5_rst_out_d", {out_d3, out_d2, out_d1, out_d0}, 32'h0);
        model_reset();
        @(posedge ap_clk);
        #1;
        ap_rst_n  = 1'b1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        cnt = 0;
        for (int cy = 0; cy < 10; cy++) begin
            in_valid = (m_done == 0);
            drive_random_row();
            tick();
            if (dut_out_fire) cnt++;
        end
        check("t5_fresh_cols", 32'(cnt), 32'd4);

        // Random stall on both sides, 1000 blocks.
        do_reset();
        cyc = 0;
        drive_random_row();
        while (m_drained < 1000 && cyc < 40000) begin
            if (!in_valid || mdl_in_fire) begin
                in_valid = 1'($urandom % 2);
                drive_random_row();
            end
            out_ready = 1'($urandom % 2);
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        check("t6_blocks_drained", 32'(m_drained), 32'd1000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
